// File: rtl/multi_channel_delay_line.sv
// Purpose : delays NUM_CH parallel lanes that share one valid bit, with a runtime-programmable depth.
// Latency : cur_delay enabled edges (0 = combinational bypass); stalled edges do not count.
// Backpr. : none. enable=0 freezes the chain, and the consumer must take out_valid on the cycle it is shown.
//
// Ports:
//   clk, reset (async, active-low)
//   enable     - 1 advances the chain; 0 holds every stage
//   flush      - clears all valid bits at the edge and drops the same-edge input
//   cfg_load   - loads min(cfg_delay, MAX_DELAY) into cur_delay and clears all valid bits
//   in_valid / in_data   - input sample; lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_valid / out_data - delayed sample, same packing
//   cur_delay  - active delay
//   busy       - any valid bit set in stages 1..cur_delay
module multi_channel_delay_line #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_CH        = 4,
    parameter int MAX_DELAY     = 8,
    parameter int DEFAULT_DELAY = 3,
    localparam int DW_CFG       = $clog2(MAX_DELAY + 1),
    localparam int BUS_W        = NUM_CH * DATA_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              flush,
    input  logic              cfg_load,
    input  logic [DW_CFG-1:0] cfg_delay,
    input  logic              in_valid,
    input  logic [BUS_W-1:0]  in_data,
    output logic              out_valid,
    output logic [BUS_W-1:0]  out_data,
    output logic [DW_CFG-1:0] cur_delay,
    output logic              busy
);

    logic [BUS_W-1:0]  stage_dat [1:MAX_DELAY];
    logic [MAX_DELAY:1] stage_vld;
    logic [DW_CFG-1:0] delay_q;
    logic [DW_CFG-1:0] delay_clamped;
    logic              clear_vld;

    // A new delay or a flush invalidates every in-flight sample, including the one arriving now.
    assign clear_vld     = flush | cfg_load;
    assign delay_clamped = (cfg_delay > DW_CFG'(MAX_DELAY)) ? DW_CFG'(MAX_DELAY) : cfg_delay;

    // Data always shifts on enable. Invalid samples are harmless because valid travels separately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i <= MAX_DELAY; i++) begin
                stage_dat[i] <= '0;
            end
        end else if (enable) begin
            stage_dat[1] <= in_data;
            for (int i = 2; i <= MAX_DELAY; i++) begin
                stage_dat[i] <= stage_dat[i-1];
            end
        end
    end

    // Flush and cfg_load act even while the chain is stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_vld <= '0;
        end else if (clear_vld) begin
            stage_vld <= '0;
        end else if (enable) begin
            stage_vld[1] <= in_valid;
            for (int i = 2; i <= MAX_DELAY; i++) begin
                stage_vld[i] <= stage_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            delay_q <= DW_CFG'(DEFAULT_DELAY);
        end else if (cfg_load) begin
            delay_q <= delay_clamped;
        end
    end

    // Tap select: a delay of 0 matches no stage, so the input defaults pass straight through.
    // Only stages up to the active tap can still reach the output, so only they count toward busy.
    always_comb begin
        out_valid = in_valid;
        out_data  = in_data;
        busy      = 1'b0;
        for (int i = 1; i <= MAX_DELAY; i++) begin
            if (delay_q == DW_CFG'(i)) begin
                out_valid = stage_vld[i];
                out_data  = stage_dat[i];
            end
            if (DW_CFG'(i) <= delay_q) begin
                busy = busy | stage_vld[i];
            end
        end
    end

    assign cur_delay = delay_q;

endmodule

// File: tb/tb_multi_channel_delay_line.sv
// Scoreboard bench for multi_channel_delay_line at default parameters (4 lanes x 32 bits, MAX_DELAY 8).
// Stimulus pushes {data, due cycle} entries. A negedge monitor pops one entry for each newly produced output.
module tb_multi_channel_delay_line;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         flush;
    logic         cfg_load;
    logic [3:0]   cfg_delay;
    logic         in_valid;
    logic [127:0] in_data;
    logic         out_valid;
    logic [127:0] out_data;
    logic [3:0]   cur_delay;
    logic         busy;

    multi_channel_delay_line dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .flush     (flush),
        .cfg_load  (cfg_load),
        .cfg_delay (cfg_delay),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .cur_delay (cur_delay),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;
    logic mon_en      = 1'b0;
    logic edge_en;

    always @(posedge clk) cyc++;

    // An output is new only if the edge that produced it advanced the chain, or in bypass.
    always @(posedge clk or negedge reset) begin
        if (!reset) edge_en <= 1'b0;
        else        edge_en <= enable;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] mk(input int n);
        logic [127:0] d;
        for (int k = 0; k < 4; k++) d[k*32 +: 32] = 32'(32'h100 * n + k);
        return d;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && (cur_delay == 4'd0 || edge_en)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", out_data, 128'h0);
                    chk("unexpected_valid", {127'h0, out_valid}, 128'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_cycle", 128'(cyc), 128'(e.due));
                end
            end
            while (sb.size() > 0 && sb[0].due < cyc) begin
                exp_t m;
                m = sb.pop_front();
                chk("missing_output_due", 128'(cyc), 128'(m.due));
            end
        end
    end

    task automatic step(input logic en, input logic vld, input logic [127:0] d,
                        input logic fl, input logic ld, input logic [3:0] cd);
        enable = en; in_valid = vld; in_data = d; flush = fl; cfg_load = ld; cfg_delay = cd;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d);
        step(1'b1, 1'b1, d, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 128'h0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic cfg(input logic [3:0] cd);
        step(1'b1, 1'b0, 128'h0, 1'b0, 1'b1, cd);
    endtask

    task automatic push(input logic [127:0] d, input int due);
        exp_t e;
        e.data = d;
        e.due  = due;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [127:0] held_d;
        logic         held_v;

        // 1: reset with random inputs, then the first sample at D=3
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            enable = 1'($urandom); in_valid = 1'($urandom); flush = 1'($urandom);
            cfg_load = 1'($urandom); cfg_delay = 4'($urandom);
            in_data = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("rst_out_valid", {127'h0, out_valid}, 128'h0);
            chk("rst_out_data", out_data, 128'h0);
            chk("rst_cur_delay", {124'h0, cur_delay}, 128'd3);
            chk("rst_busy", {127'h0, busy}, 128'h0);
        end
        @(posedge clk); #1;
        enable = 1'b1; in_valid = 1'b0; flush = 1'b0; cfg_load = 1'b0; cfg_delay = 4'd0; in_data = '0;
        reset = 1'b1;
        mon_en = 1'b1;
        idle(2);
        push(128'hA5, cyc + 3);
        send(128'hA5);
        chk("busy_inflight", {127'h0, busy}, 128'h1);
        idle(5);

        // 2: ten-sample multi-lane burst at D=3
        for (int n = 0; n < 10; n++) begin
            push(mk(n), cyc + 3);
            send(mk(n));
        end
        idle(5);

        // 3: stall for 4 cycles mid-burst. Samples 3 and 4 straddle the stall.
        k = cyc;
        push(mk(32'h20), k + 3);
        push(mk(32'h21), k + 4);
        push(mk(32'h22), k + 5);
        push(mk(32'h23), k + 10);
        push(mk(32'h24), k + 11);
        push(mk(32'h25), k + 12);
        push(mk(32'h26), k + 13);
        push(mk(32'h27), k + 14);
        for (int i = 0; i < 5; i++) send(mk(32'h20 + i));
        held_d = out_data;
        held_v = out_valid;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 128'hDEAD, 1'b0, 1'b0, 4'd0);
            chk("stall_hold_data", out_data, held_d);
            chk("stall_hold_valid", {127'h0, out_valid}, {127'h0, held_v});
        end
        for (int i = 5; i < 8; i++) send(mk(32'h20 + i));
        idle(6);

        // 4: reconfigure while samples are in flight, then test the clamp
        send(mk(32'h30));
        send(mk(32'h31));
        step(1'b1, 1'b1, mk(32'h32), 1'b0, 1'b1, 4'd6);
        chk("cfg6_cur_delay", {124'h0, cur_delay}, 128'd6);
        chk("cfg6_busy", {127'h0, busy}, 128'h0);
        idle(8);
        push(mk(32'h40), cyc + 6);
        send(mk(32'h40));
        idle(8);
        cfg(4'd15);
        chk("cfg15_clamp", {124'h0, cur_delay}, 128'd8);

        // 5: flush with a same-edge input, then the next sample passes normally
        cfg(4'd3);
        idle(2);
        send(mk(32'h50));
        send(mk(32'h51));
        step(1'b1, 1'b1, mk(32'h52), 1'b1, 1'b0, 4'd0);
        chk("flush_busy", {127'h0, busy}, 128'h0);
        chk("flush_out_valid", {127'h0, out_valid}, 128'h0);
        push(mk(32'h53), cyc + 3);
        send(mk(32'h53));
        idle(5);
        send(mk(32'h54));
        step(1'b1, 1'b0, 128'h0, 1'b1, 1'b1, 4'd2);
        chk("flush_cfg_delay", {124'h0, cur_delay}, 128'd2);
        chk("flush_cfg_busy", {127'h0, busy}, 128'h0);
        idle(4);

        // 6: bypass, then an async reset in the middle of a D=5 burst
        cfg(4'd0);
        chk("bypass_cur_delay", {124'h0, cur_delay}, 128'd0);
        for (int i = 0; i < 3; i++) begin
            push(mk(32'h60 + i), cyc);
            send(mk(32'h60 + i));
        end
        idle(2);
        cfg(4'd5);
        k = cyc;
        push(mk(32'h70), k + 5);
        for (int i = 0; i < 6; i++) send(mk(32'h70 + i));
        chk("pre_reset_valid", {127'h0, out_valid}, 128'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", {127'h0, out_valid}, 128'h0);
        chk("async_rst_data", out_data, 128'h0);
        chk("async_rst_busy", {127'h0, busy}, 128'h0);
        chk("async_rst_delay", {124'h0, cur_delay}, 128'd3);
        @(posedge clk); #1;
        reset = 1'b1;
        idle(6);
        push(mk(32'h80), cyc + 3);
        send(mk(32'h80));
        idle(8);

        chk("scoreboard_drained", 128'(sb.size()), 128'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
